// File: rtl/io_tx_buffer.sv
// io_tx_buffer: CPU-to-UART byte FIFO with back-pressure and program-stop sequencing.
// Optional feature macro IO_CYCLE_COUNTER_EN builds the free-running cycle_count register.
module io_tx_buffer #(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        overflow,
  output logic [31:0] cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH - FULL_MARGIN);
  localparam logic [AW:0] MAX_LVL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, SEND_NUL, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          io_wr, data_wr, stop_wr, push_req, push, pop;
  logic          unused_addr;

  assign unused_addr = ^{mem_a[31:18], mem_a[15:3]};

  assign io_wr    = mem_wr && rdy_in && (mem_a[17:16] == 2'b11);
  assign data_wr  = io_wr && (mem_a[2:0] == 3'd0);
  assign stop_wr  = io_wr && (mem_a[2:0] == 3'd4);
  assign push_req = data_wr && (mem_dout != 8'h00) && (state == IDLE);
  // count!=0 already implies tx_valid, so the handshake reduces to tx_ready
  assign pop      = tx_ready && (count != '0);
  // a full FIFO still accepts a byte when the head is leaving on the same edge
  assign push     = push_req && ((count != MAX_LVL) || pop);

  always_ff @(posedge clk_in) begin
    if (push) mem[tail] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    tx_valid       = (count != '0);
    tx_data        = mem[head];
    io_buffer_full = (count >= FULL_LVL);
    program_done   = 1'b0;
    case (state)
      IDLE: begin
        if (stop_wr) state_nxt = DRAIN;
      end
      DRAIN: begin
        io_buffer_full = 1'b1;
        if (count == '0) state_nxt = SEND_NUL;
      end
      SEND_NUL: begin
        io_buffer_full = 1'b1;
        tx_valid       = 1'b1;
        tx_data        = 8'h00;
        if (tx_ready) state_nxt = DONE;
      end
      DONE: begin
        io_buffer_full = 1'b1;
        program_done   = 1'b1;
      end
    endcase
  end

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) cycle_cnt <= '0;
    else         cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_count = cycle_cnt;
`else
  assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_io_tx_buffer.sv
// Randomized self-checking bench for io_tx_buffer against a queue-based reference model.
module tb_io_tx_buffer;

  localparam int DEPTH       = 16;
  localparam int FULL_MARGIN = 2;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_NUL = 2, M_DONE = 3;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        program_done;
  logic        overflow;
  logic [31:0] cycle_count;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q[$];
  logic [7:0]  rx[$];
  logic [7:0]  exp_rx[$];
  int          mode = M_IDLE;
  bit          m_ovf = 1'b0;
  logic [31:0] m_cycles = '0;

  io_tx_buffer #(.DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .program_done(program_done), .overflow(overflow), .cycle_count(cycle_count)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock: apply inputs, compare against model, then advance model across the edge
  task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d,
                      input logic rdy, input logic txr);
    bit         io, dw, sw, m_valid, acc;
    logic [7:0] m_data;
    int         old_mode, old_size;
    mem_wr = wr; mem_a = a; mem_dout = d; rdy_in = rdy; tx_ready = txr;
    #1;
    m_valid = (q.size() != 0) || (mode == M_NUL);
    m_data  = (mode == M_NUL || q.size() == 0) ? 8'h00 : q[0];
    chk("tx_valid", 32'(tx_valid), 32'(m_valid));
    if (m_valid) chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("io_buffer_full", 32'(io_buffer_full),
        32'((q.size() >= DEPTH - FULL_MARGIN) || (mode != M_IDLE)));
    chk("program_done", 32'(program_done), 32'(mode == M_DONE));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef IO_CYCLE_COUNTER_EN
    chk("cycle_count", cycle_count, m_cycles);
`else
    chk("cycle_count", cycle_count, 32'h0);
`endif
    if (tx_valid && txr) rx.push_back(tx_data);
    io = wr && rdy && (a[17:16] == 2'b11);
    dw = io && (a[2:0] == 3'd0);
    sw = io && (a[2:0] == 3'd4);
    acc = m_valid && txr;
    old_mode = mode;
    old_size = q.size();
    if (acc) begin
      if (old_mode == M_NUL) mode = M_DONE;
      else void'(q.pop_front());
    end
    if (old_mode == M_DRAIN && old_size == 0) mode = M_NUL;
    if (old_mode == M_IDLE && sw) mode = M_DRAIN;
    if (old_mode == M_IDLE && dw && d != 8'h00) begin
      if (old_size < DEPTH || acc) q.push_back(d);
      else m_ovf = 1'b1;
    end
    m_cycles = m_cycles + 32'd1;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h00, 1'b1, txr);
  endtask

  task automatic do_reset();
    #2;
    rst_in = 1'b0;
    #1;
    chk("rst tx_valid", 32'(tx_valid), 32'h0);
    chk("rst io_buffer_full", 32'(io_buffer_full), 32'h0);
    chk("rst program_done", 32'(program_done), 32'h0);
    chk("rst overflow", 32'(overflow), 32'h0);
    chk("rst cycle_count", cycle_count, 32'h0);
    mem_wr = 1'b0; mem_a = '0; mem_dout = '0; rdy_in = 1'b0; tx_ready = 1'b0;
    q.delete(); rx.delete();
    mode = M_IDLE; m_ovf = 1'b0; m_cycles = '0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    chk({tag, " len"}, 32'(rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx.size(); i++)
      chk(tag, 32'(rx[i]), 32'(exp_rx[i]));
  endtask

  logic [31:0] addr_set [6] = '{32'h0003_0000, 32'h0003_0008, 32'hABC3_0000,
                                32'h0002_0000, 32'h0003_0001, 32'h0000_0100};

  initial begin
    logic [7:0] sent[$];
    logic [7:0] b;
    int         guard;

    @(negedge clk_in);
    do_reset();

    // single byte with UART idle
    step(1'b1, 32'h0003_0000, 8'h41, 1'b1, 1'b1);
    idle(3, 1'b1);
    exp_rx = {8'h41};
    check_rx("single");

    // fill, back-pressure and overflow
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'h0003_0000, 8'(i), 1'b1, 1'b0);
      chk("fill full", 32'(io_buffer_full), 32'(i >= 14));
    end
    step(1'b1, 32'h0003_0000, 8'h11, 1'b1, 1'b0);
    chk("fill overflow", 32'(overflow), 32'h1);
    idle(20, 1'b1);
    exp_rx.delete();
    for (int i = 1; i <= 16; i++) exp_rx.push_back(8'(i));
    check_rx("fill order");

    // wrap-around stream honoring back-pressure
    do_reset();
    sent.delete();
    guard = 0;
    while (sent.size() < 40 && guard < 300) begin
      b = 8'($urandom_range(1, 255));
      if (!io_buffer_full) begin
        step(1'b1, 32'h0003_0000, b, 1'b1, guard[0]);
        sent.push_back(b);
      end else begin
        step(1'b0, 32'h0003_0000, b, 1'b1, guard[0]);
      end
      guard++;
    end
    chk("stream sent", 32'(sent.size()), 32'd40);
    idle(30, 1'b1);
    chk("stream overflow", 32'(overflow), 32'h0);
    exp_rx = sent;
    check_rx("stream order");

    // NUL data and address/ready filtering
    do_reset();
    step(1'b1, 32'h0003_0000, 8'h00, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0100, 8'h55, 1'b1, 1'b0);
    step(1'b1, 32'h0003_0000, 8'h55, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("filter tx_valid", 32'(tx_valid), 32'h0);

    // randomized traffic, then stop sequence with random UART stalls
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), addr_set[$urandom_range(0, 5)],
           ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    step(1'b1, 32'h0003_0004, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
    guard = 0;
    while (mode != M_DONE && guard < 200) begin
      step(1'b1, 32'h0003_0000, 8'($urandom_range(1, 255)), 1'b1, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("random stop done", 32'(program_done), 32'h1);

    // directed stop sequence
    do_reset();
    step(1'b1, 32'h0003_0000, 8'h61, 1'b1, 1'b0);
    step(1'b1, 32'h0003_0000, 8'h62, 1'b1, 1'b0);
    step(1'b1, 32'h0003_0004, 8'h00, 1'b1, 1'b0);
    chk("stop full", 32'(io_buffer_full), 32'h1);
    step(1'b1, 32'h0003_0000, 8'h63, 1'b1, 1'b0);
    idle(8, 1'b1);
    exp_rx = {8'h61, 8'h62, 8'h00};
    check_rx("stop rx");
    chk("stop done", 32'(program_done), 32'h1);
    chk("stop full hold", 32'(io_buffer_full), 32'h1);

    // mid-operation reset with bytes queued, then counter run
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0003_0000, 8'(8'h70 + i), 1'b1, 1'b0);
    do_reset();
    idle(100, 1'b0);
`ifdef IO_CYCLE_COUNTER_EN
    chk("cycle_count 100", cycle_count, 32'd100);
`else
    chk("cycle_count off", cycle_count, 32'd0);
`endif
    chk("post reset tx_valid", 32'(tx_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_tx_buffer.md
# io_tx_buffer

Buffered output channel between the CPU memory bus and the UART transmitter. It captures CPU writes to the memory-mapped output port 0x30000 into a byte FIFO and drains them to the UART over a valid/ready handshake. It drives `io_buffer_full` back to the CPU, and sequences the program-stop write to 0x30004 into a final NUL byte plus a `program_done` flag.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, minimum 4.
- `FULL_MARGIN`, default 2: free entries still remaining when `io_buffer_full` rises; covers CPU writes already in flight.

Ports:
- `clk_in`  input  1  system clock; one clock domain.
- `rst_in`  input  1  asynchronous, active-low reset.
- `rdy_in`  input  1  CPU ready; CPU-side writes are sampled only while high.
- `mem_a`  input  32  CPU address bus; only bits 17:0 are decoded.
- `mem_wr`  input  1  CPU write strobe; 1 = write.
- `mem_dout`  input  8  CPU write data.
- `io_buffer_full`  output  1  back-pressure to the CPU.
- `tx_data`  output  8  byte offered to the UART.
- `tx_valid`  output  1  `tx_data` is valid.
- `tx_ready`  input  1  UART accepts the byte this cycle.
- `program_done`  output  1  stop byte sent; sticky until reset.
- `overflow`  output  1  sticky; a byte was dropped because the FIFO was full.
- `cycle_count`  output  32  clock cycles since reset release.

## Operation
- Decode: an I/O write is `mem_wr && rdy_in && mem_a[17:16]==2'b11`.
  - Data write: the above with `mem_a[2:0]==0`.
  - Stop write: the above with `mem_a[2:0]==4`.
  - All other addresses are ignored.
- Data write with `mem_dout==0`: ignored, no push.
- Data write with a nonzero byte while FSM is in IDLE: push `mem_dout` at `tail`.
- FIFO storage: `mem[DEPTH]`, pointers `head`/`tail` of log2(DEPTH) bits that wrap modulo DEPTH, and `count` of log2(DEPTH)+1 bits.
- Push with `count==DEPTH` and no pop in the same cycle: byte dropped, `overflow` set, pointers and count unchanged.
- Pop: occurs when `tx_valid && tx_ready` while the FIFO is non-empty. Advances `head`.
- Simultaneous push and pop: both take effect and `count` is unchanged. This is legal even when `count==DEPTH`.
- `tx_valid = (count!=0) || state==SEND_NUL`.
- `tx_data = state==SEND_NUL ? 8'h00 : mem[head]`.
- `tx_data` is held stable while `tx_valid && !tx_ready`.
- `io_buffer_full = (count >= DEPTH-FULL_MARGIN) || state!=IDLE`.
- Stop FSM states and transitions:
  - IDLE: stop write → DRAIN.
  - DRAIN: data writes ignored; when `count==0` → SEND_NUL.
  - SEND_NUL: NUL byte offered; `tx_ready` → DONE.
  - DONE: `program_done=1`; all CPU writes ignored; FSM stays here until reset.
- A data write and a stop write cannot occur in the same cycle (one bus). A stop write in any state other than IDLE is ignored.
- Draining to the UART continues regardless of `rdy_in`.
- `cycle_count` increments by 1 every clock edge after reset release and wraps at 2^32.

## Timing
- Reset (`rst_in` low, asynchronous) clears:
  - `head`, `tail`, `count` → 0.
  - FSM → IDLE.
  - `overflow`, `program_done`, `cycle_count` → 0.
- Resulting output values in reset: `tx_valid`=0, `io_buffer_full`=0. FIFO contents are don't-care.
- Assertion of reset mid-transfer aborts immediately; the in-flight byte is lost.
- Reset release is synchronized by the environment; the first active edge counts `cycle_count` to 1.
- Latency: a write at edge N makes `tx_valid` high after edge N when the FIFO was empty, so the byte is visible in cycle N+1.
- `io_buffer_full` is combinational from registered state. It therefore reflects a push one cycle after the write edge.
- The CPU may issue at most `FULL_MARGIN` writes after `io_buffer_full` rises; no loss occurs within that margin.
- Throughput: one byte per cycle in each direction.
- Stop sequence: DRAIN → SEND_NUL transition takes one edge after the last pop. `program_done` rises on the edge that accepts the NUL byte.

## Configuration
- `IO_CYCLE_COUNTER_EN`
  - Defined: the 32-bit `cycle_count` register is built as specified above.
  - Undefined: no counter register exists and `cycle_count` is tied to 32'h0. All other behaviour is identical.

## Test plan
- Single byte, UART idle:
  - Stimulus: reset, then write 0x41 to 0x30000 with `tx_ready`=1.
  - Required: `tx_valid`=1 with `tx_data`=0x41 for exactly one cycle; `count` returns to 0.
- Fill and back-pressure (DEPTH=16, FULL_MARGIN=2, `tx_ready`=0):
  - Stimulus: write 0x01..0x10.
  - Required: `io_buffer_full` rises after the 14th push. The 17th write 0x11 is dropped and sets `overflow`. Releasing `tx_ready` yields 0x01..0x10 in order.
- Wrap-around and simultaneous push/pop:
  - Stimulus: 40 bytes streamed with `tx_ready` toggling 1/0.
  - Required: output sequence equals input sequence; no `overflow`.
- NUL and address filtering:
  - Stimulus: writes of 0x00 to 0x30000, 0x55 to 0x00100, and 0x55 with `rdy_in`=0.
  - Required: no push for any of them; `tx_valid` stays 0.
- Stop sequence:
  - Stimulus: push 0x61, 0x62, then write to 0x30004, then write 0x63.
  - Required: UART receives exactly 0x61, 0x62, 0x00. `program_done`=1 after the NUL is accepted. `io_buffer_full`=1 from the stop write onward.
- Mid-operation reset:
  - Stimulus: assert `rst_in` low with 5 bytes queued.
  - Required: asynchronously `tx_valid`=0, `cycle_count`=0, `program_done`=0.
  - With `IO_CYCLE_COUNTER_EN` defined: after 100 cycles out of reset, `cycle_count`=100. With it undefined: `cycle_count`=0.
